// File: rtl/iact_mcast_if.sv
// iact_mcast_if: config, router-beat and PE-side handshake bundle for iact_mcast_ctrl
interface iact_mcast_if #(
    parameter int NUM_ROUTERS = 3,
    parameter int PE_ROWS     = 3,
    parameter int PE_COLS     = 4,
    parameter int NUM_SETS    = 4
);
    localparam int NUM_PE = PE_ROWS * PE_COLS;
    localparam int RW     = NUM_ROUTERS > 1 ? $clog2(NUM_ROUTERS) : 1;
    localparam int PW     = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
    localparam int SW     = NUM_SETS > 1 ? $clog2(NUM_SETS) : 1;

    logic                        cfg_clear;
    logic                        cfg_valid;
    logic                        cfg_ready;
    logic [PW-1:0]               cfg_pe;
    logic [RW-1:0]               cfg_router;
    logic [SW-1:0]               cfg_set;
    logic                        cfg_done;
    logic                        run_active;
    logic [NUM_ROUTERS-1:0]      rt_valid;
    logic [NUM_ROUTERS-1:0]      rt_ready;
    logic [NUM_PE-1:0]           pe_ready;
    logic [NUM_PE-1:0]           pe_valid;
    logic [NUM_PE*RW-1:0]        pe_sel;
    logic [NUM_ROUTERS*SW-1:0]   rt_set;
    logic [NUM_ROUTERS*16-1:0]   stall_cnt;

    modport master (
        output cfg_clear, cfg_valid, cfg_pe, cfg_router, cfg_set, cfg_done, rt_valid, pe_ready,
        input  cfg_ready, run_active, rt_ready, pe_valid, pe_sel, rt_set, stall_cnt
    );

    modport slave (
        input  cfg_clear, cfg_valid, cfg_pe, cfg_router, cfg_set, cfg_done, rt_valid, pe_ready,
        output cfg_ready, run_active, rt_ready, pe_valid, pe_sel, rt_set, stall_cnt
    );
endinterface

// File: rtl/iact_mcast_ctrl.sv
// iact_mcast_ctrl: iact multicast routing-table controller; IACT_MCAST_STATS_EN adds per-router stall counters
module iact_mcast_ctrl #(
    parameter int NUM_ROUTERS = 3,
    parameter int PE_ROWS     = 3,
    parameter int PE_COLS     = 4,
    parameter int NUM_SETS    = 4,
    parameter int BURST_LEN   = 4
) (
    input logic         clk,
    input logic         rstn,
    iact_mcast_if.slave bus
);
    localparam int NUM_PE = PE_ROWS * PE_COLS;
    localparam int RW     = NUM_ROUTERS > 1 ? $clog2(NUM_ROUTERS) : 1;
    localparam int SW     = NUM_SETS > 1 ? $clog2(NUM_SETS) : 1;
    localparam int BW     = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;

    typedef enum logic {CFG, RUN} state_e;

    state_e                 state_q, state_d;
    logic [NUM_PE-1:0]      mask_q [NUM_ROUTERS][NUM_SETS];
    logic [NUM_PE-1:0]      mask_d [NUM_ROUTERS][NUM_SETS];
    logic [RW-1:0]          sel_q [NUM_PE];
    logic [RW-1:0]          sel_d [NUM_PE];
    logic [SW-1:0]          set_q [NUM_ROUTERS];
    logic [SW-1:0]          set_d [NUM_ROUTERS];
    logic [BW-1:0]          cnt_q [NUM_ROUTERS];
    logic [BW-1:0]          cnt_d [NUM_ROUTERS];
    logic [NUM_PE-1:0]      cur_mask [NUM_ROUTERS];
    logic [NUM_ROUTERS-1:0] rdy;
    logic [NUM_ROUTERS-1:0] xfer;
    logic                   run;
    logic                   entry_ok;

    assign run            = state_q == RUN;
    assign bus.cfg_ready  = !run;
    assign bus.run_active = run;
    assign bus.rt_ready   = rdy;
    assign entry_ok       = bus.cfg_valid && int'(bus.cfg_pe) < NUM_PE &&
                            int'(bus.cfg_router) < NUM_ROUTERS && int'(bus.cfg_set) < NUM_SETS;

    // All-or-nothing fan-out: a router is ready only when every PE of its current set is ready
    always_comb begin
        bus.pe_valid = '0;
        for (int r = 0; r < NUM_ROUTERS; r++) begin
            cur_mask[r] = mask_q[r][set_q[r]];
            rdy[r]      = run && &(bus.pe_ready | ~cur_mask[r]);
            xfer[r]     = bus.rt_valid[r] && rdy[r];
            if (xfer[r])
                bus.pe_valid = bus.pe_valid | cur_mask[r];
        end
    end

    // Flatten per-PE selects and per-router set pointers onto the output buses
    always_comb begin
        bus.pe_sel = '0;
        bus.rt_set = '0;
        for (int p = 0; p < NUM_PE; p++)
            bus.pe_sel[p*RW +: RW] = sel_q[p];
        for (int r = 0; r < NUM_ROUTERS; r++)
            bus.rt_set[r*SW +: SW] = set_q[r];
    end

    // Table writes, CFG/RUN sequencing and per-router burst/set advance
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        set_d   = set_q;
        cnt_d   = cnt_q;
        if (bus.cfg_clear) begin
            state_d = CFG;
            mask_d  = '{default: '0};
            sel_d   = '{default: '0};
            set_d   = '{default: '0};
            cnt_d   = '{default: '0};
        end else if (!run) begin
            if (entry_ok) begin
                for (int r = 0; r < NUM_ROUTERS; r++)
                    for (int s = 0; s < NUM_SETS; s++)
                        mask_d[r][s][bus.cfg_pe] = 1'b0;
                mask_d[bus.cfg_router][bus.cfg_set][bus.cfg_pe] = 1'b1;
                sel_d[bus.cfg_pe] = bus.cfg_router;
            end
            if (bus.cfg_done) begin
                state_d = RUN;
                set_d   = '{default: '0};
                cnt_d   = '{default: '0};
            end
        end else begin
            for (int r = 0; r < NUM_ROUTERS; r++) begin
                if (xfer[r]) begin
                    if (cnt_q[r] == BW'(BURST_LEN - 1)) begin
                        cnt_d[r] = '0;
                        set_d[r] = set_q[r] == SW'(NUM_SETS - 1) ? '0 : set_q[r] + 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] + 1'b1;
                    end
                end
            end
        end
    end

    // State, table and counter registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= CFG;
            mask_q  <= '{default: '0};
            sel_q   <= '{default: '0};
            set_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            set_q   <= set_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef IACT_MCAST_STATS_EN
    logic [15:0] stall_q [NUM_ROUTERS];
    logic [15:0] stall_d [NUM_ROUTERS];

    // Saturating count of RUN cycles where a router offers a beat that cannot go out
    always_comb begin
        stall_d = stall_q;
        if (bus.cfg_clear)
            stall_d = '{default: '0};
        else
            for (int r = 0; r < NUM_ROUTERS; r++)
                if (run && bus.rt_valid[r] && !rdy[r] && stall_q[r] != 16'hFFFF)
                    stall_d[r] = stall_q[r] + 16'd1;
    end

    // Stall counter registers
    always_ff @(posedge clk) begin
        if (!rstn)
            stall_q <= '{default: '0};
        else
            stall_q <= stall_d;
    end

    // Flatten stall counters onto the output bus
    always_comb begin
        bus.stall_cnt = '0;
        for (int r = 0; r < NUM_ROUTERS; r++)
            bus.stall_cnt[r*16 +: 16] = stall_q[r];
    end
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_iact_mcast_ctrl.sv
// tb_iact_mcast_ctrl: vector table, directed corner sequences and random traffic against an ownership model
module tb_iact_mcast_ctrl;
    localparam int NR = 3, PR = 3, PC = 4, NS = 4, BL = 4;
    localparam int NP = PR * PC, RW = 2, SW = 2;
`ifdef IACT_MCAST_STATS_EN
    localparam int STALL_EXP = 7;
`else
    localparam int STALL_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    iact_mcast_if #(.NUM_ROUTERS(NR), .PE_ROWS(PR), .PE_COLS(PC), .NUM_SETS(NS)) bus();

    iact_mcast_ctrl #(.NUM_ROUTERS(NR), .PE_ROWS(PR), .PE_COLS(PC), .NUM_SETS(NS), .BURST_LEN(BL)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    int n_chk = 0, n_err = 0;

    // Reference model: which (router,set) owns each PE, and total beats taken per router
    int own_r [NP];
    int own_s [NP];
    int m_sel [NP];
    int beats [NR];
    int stl   [NR];
    bit m_run;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int p = 0; p < NP; p++) begin own_r[p] = -1; own_s[p] = -1; m_sel[p] = 0; end
        for (int r = 0; r < NR; r++) begin beats[r] = 0; stl[r] = 0; end
        m_run = 0;
    endfunction

    function automatic logic [NP-1:0] m_mask(int r);
        logic [NP-1:0] m = '0;
        int s = (beats[r] / BL) % NS;
        for (int p = 0; p < NP; p++)
            if (own_r[p] == r && own_s[p] == s) m[p] = 1'b1;
        return m;
    endfunction

    function automatic logic [NR-1:0] m_rdy();
        logic [NR-1:0] v = '0;
        for (int r = 0; r < NR; r++)
            v[r] = m_run && ((m_mask(r) & ~bus.pe_ready) == '0);
        return v;
    endfunction

    function automatic void check_all();
        logic [NR-1:0]    rd = m_rdy();
        logic [NP-1:0]    pv = '0;
        logic [NR*SW-1:0] st = '0;
        logic [NP*RW-1:0] ps = '0;
        logic [NR*16-1:0] sc = '0;
        for (int r = 0; r < NR; r++) begin
            if (bus.rt_valid[r] && rd[r]) pv = pv | m_mask(r);
            st[r*SW +: SW] = SW'((beats[r] / BL) % NS);
`ifdef IACT_MCAST_STATS_EN
            sc[r*16 +: 16] = 16'(stl[r]);
`endif
        end
        for (int p = 0; p < NP; p++) ps[p*RW +: RW] = RW'(m_sel[p]);
        chk("m.cfg_ready", 64'(bus.cfg_ready), 64'(!m_run));
        chk("m.run_active", 64'(bus.run_active), 64'(m_run));
        chk("m.rt_ready", 64'(bus.rt_ready), 64'(rd));
        chk("m.pe_valid", 64'(bus.pe_valid), 64'(pv));
        chk("m.pe_sel", 64'(bus.pe_sel), 64'(ps));
        chk("m.rt_set", 64'(bus.rt_set), 64'(st));
        chk("m.stall_cnt", 64'(bus.stall_cnt), 64'(sc));
    endfunction

    function automatic void m_step();
        logic [NR-1:0] rd = m_rdy();
        if (!rstn || bus.cfg_clear) begin
            m_reset();
        end else if (!m_run) begin
            if (bus.cfg_valid && int'(bus.cfg_pe) < NP && int'(bus.cfg_router) < NR) begin
                own_r[bus.cfg_pe] = int'(bus.cfg_router);
                own_s[bus.cfg_pe] = int'(bus.cfg_set);
                m_sel[bus.cfg_pe] = int'(bus.cfg_router);
            end
            if (bus.cfg_done) begin
                m_run = 1;
                for (int r = 0; r < NR; r++) beats[r] = 0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (bus.rt_valid[r] && rd[r]) beats[r]++;
                else if (bus.rt_valid[r] && stl[r] < 65535) stl[r]++;
            end
        end
    endfunction

    task automatic tick();
        #1;
        check_all();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int pe, input int r, input int s, input bit done);
        bus.cfg_valid = 1'b1;
        bus.cfg_pe = 4'(pe);
        bus.cfg_router = 2'(r);
        bus.cfg_set = 2'(s);
        bus.cfg_done = done;
        tick();
        bus.cfg_valid = 1'b0;
        bus.cfg_done = 1'b0;
    endtask

    typedef struct {
        logic [NR-1:0] rv;
        logic [NP-1:0] pr;
        logic [NR-1:0] e_rdy;
        logic [NP-1:0] e_pv;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{3'b010, 12'hFFF, 3'b111, 12'h007};
        vt[1] = '{3'b010, 12'hFFB, 3'b101, 12'h000};
        vt[2] = '{3'b000, 12'hFFF, 3'b111, 12'h000};
        vt[3] = '{3'b010, 12'h007, 3'b111, 12'h007};
        vt[4] = '{3'b010, 12'h006, 3'b101, 12'h000};
        vt[5] = '{3'b111, 12'hFFF, 3'b111, 12'h007};

        rstn = 1'b0;
        bus.cfg_clear = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_done = 1'b0;
        bus.cfg_pe = '0; bus.cfg_router = '0; bus.cfg_set = '0;
        bus.rt_valid = 3'b111; bus.pe_ready = 12'hFFF;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("rst run_active", 64'(bus.run_active), 64'd0);
        chk("rst rt_ready", 64'(bus.rt_ready), 64'd0);
        chk("rst pe_valid", 64'(bus.pe_valid), 64'd0);
        chk("rst pe_sel", 64'(bus.pe_sel), 64'd0);
        chk("rst rt_set", 64'(bus.rt_set), 64'd0);
        rstn = 1'b1;
        bus.rt_valid = '0;

        cfg(0, 1, 0, 0);
        cfg(1, 1, 0, 0);
        cfg(2, 1, 0, 0);
        cfg(5, 0, 2, 0);
        cfg(5, 2, 1, 1);
        chk("pe_sel5", 64'(bus.pe_sel[5*RW +: RW]), 64'd2);
        chk("run after done", 64'(bus.run_active), 64'd1);

        for (int i = 0; i < 6; i++) begin
            bus.rt_valid = vt[i].rv;
            bus.pe_ready = vt[i].pr;
            #1;
            chk($sformatf("vec%0d rt_ready", i), 64'(bus.rt_ready), 64'(vt[i].e_rdy));
            chk($sformatf("vec%0d pe_valid", i), 64'(bus.pe_valid), 64'(vt[i].e_pv));
            tick();
        end

        bus.rt_valid = 3'b010; bus.pe_ready = 12'hFFF;
        chk("r1 set before 4th beat", 64'(bus.rt_set[3:2]), 64'd0);
        tick();
        chk("r1 set after 4 beats", 64'(bus.rt_set[3:2]), 64'd1);
        repeat (4) tick();
        chk("r1 set after 8 beats", 64'(bus.rt_set[3:2]), 64'd2);
        repeat (8) tick();
        chk("r1 set wrap after 16", 64'(bus.rt_set[3:2]), 64'd0);

        bus.rt_valid = 3'b100;
        repeat (3) tick();
        chk("r2 set after 4 beats", 64'(bus.rt_set[5:4]), 64'd1);
        bus.pe_ready = 12'hFFF & ~12'h020;
        #1;
        chk("r2 blocked rt_ready", 64'(bus.rt_ready[2]), 64'd0);
        chk("r2 blocked pe_valid", 64'(bus.pe_valid), 64'd0);
        tick();
        bus.pe_ready = 12'hFFF;
        #1;
        chk("r2 set1 rt_ready", 64'(bus.rt_ready[2]), 64'd1);
        chk("r2 set1 pe_valid", 64'(bus.pe_valid), 64'h020);
        tick();

        bus.rt_valid = 3'b010; bus.pe_ready = 12'hFFE;
        repeat (5) tick();
        bus.rt_valid = '0; bus.pe_ready = 12'hFFF;
        chk("stall_cnt r1", 64'(bus.stall_cnt[31:16]), 64'(STALL_EXP));

        bus.cfg_valid = 1'b1; bus.cfg_pe = 4'd3; bus.cfg_router = 2'd2; bus.cfg_set = 2'd0;
        #1;
        chk("run cfg_ready", 64'(bus.cfg_ready), 64'd0);
        tick();
        chk("run entry ignored", 64'(bus.pe_sel[3*RW +: RW]), 64'd0);
        bus.cfg_clear = 1'b1; bus.cfg_done = 1'b1;
        tick();
        bus.cfg_clear = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_done = 1'b0;
        chk("clear run_active", 64'(bus.run_active), 64'd0);
        chk("clear cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("clear pe_sel", 64'(bus.pe_sel), 64'd0);
        tick();

        cfg(0, 1, 0, 1);
        bus.rt_valid = 3'b010;
        repeat (5) tick();
        chk("pre-rst r1 set", 64'(bus.rt_set[3:2]), 64'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1; bus.rt_valid = '0;
        chk("rst mid run_active", 64'(bus.run_active), 64'd0);
        chk("rst mid rt_set", 64'(bus.rt_set), 64'd0);
        bus.cfg_done = 1'b1;
        tick();
        bus.cfg_done = 1'b0; bus.rt_valid = 3'b010;
        repeat (3) tick();
        chk("post-rst 3 beats", 64'(bus.rt_set[3:2]), 64'd0);
        tick();
        chk("post-rst 4 beats", 64'(bus.rt_set[3:2]), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            rstn = $urandom_range(0, 499) != 0;
            bus.cfg_clear = $urandom_range(0, 199) == 0;
            bus.cfg_valid = 1'($urandom_range(0, 1));
            bus.cfg_pe = 4'($urandom_range(0, 15));
            bus.cfg_router = 2'($urandom_range(0, 3));
            bus.cfg_set = 2'($urandom_range(0, 3));
            bus.cfg_done = m_run ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            bus.rt_valid = 3'($urandom);
            for (int p = 0; p < NP; p++) bus.pe_ready[p] = $urandom_range(0, 15) != 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/iact_mcast_ctrl.md
Name: iact_mcast_ctrl

Overview:
Parametrised input-activation multicast controller for one PE cluster, generalising the existing cluster iact control. A handshaked config port fills a routing table: per router, per set, a mask of destination PEs. At run time each router's beats go all-or-nothing to its current set's PEs. Each router's active set advances automatically after a programmable burst length. The block is control only: it emits per-PE valids and router selects, and iact data travels on the existing buses.

Parameters:
NUM_ROUTERS, 3, number of iact routers feeding the cluster
PE_ROWS, 3, PE rows in cluster
PE_COLS, 4, PE columns in cluster
NUM_SETS, 4, routing sets per router
BURST_LEN, 4, beats per set before that router's set pointer advances (>=1)
(derived) NUM_PE=PE_ROWS*PE_COLS; RW=max(1,clog2(NUM_ROUTERS)); PW=max(1,clog2(NUM_PE)); SW=max(1,clog2(NUM_SETS))

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cfg_clear  in  1  synchronous table/counter clear, returns FSM to CFG
cfg_valid  in  1  config entry valid
cfg_ready  out  1  config entry accepted when cfg_valid&cfg_ready
cfg_pe  in  PW  PE index of entry
cfg_router  in  RW  router the PE listens to
cfg_set  in  SW  set in which the PE receives
cfg_done  in  1  end of configuration, CFG->RUN
run_active  out  1  1 in RUN state
rt_valid  in  NUM_ROUTERS  per-router beat valid
rt_ready  out  NUM_ROUTERS  per-router beat ready
pe_ready  in  NUM_PE  per-PE iact ready
pe_valid  out  NUM_PE  per-PE iact valid (multicast fan-out)
pe_sel  out  NUM_PE*RW  per-PE router select, PE p at [p*RW +: RW]
rt_set  out  NUM_ROUTERS*SW  current set pointer per router
stall_cnt  out  NUM_ROUTERS*16  per-router stall counters (optional feature)

Behaviour:
- Reset (rstn=0): state=CFG, all masks=0, pe_sel=0, set pointers=0, beat counters=0, stall_cnt=0. Outputs after reset: cfg_ready=1, run_active=0, rt_ready=0, pe_valid=0.
- Table: mask[r][s] is NUM_PE bits.
- Accepted entry (CFG only): clear bit cfg_pe in every mask[*][*], then set mask[cfg_router][cfg_set][cfg_pe]. pe_sel[cfg_pe]<=cfg_router. Visible next cycle.
- Each PE therefore belongs to at most one (router,set). The last write wins.
- Out-of-range cfg_pe (>=NUM_PE) or cfg_router (>=NUM_ROUTERS): entry accepted and ignored.
- FSM CFG: cfg_ready=1. cfg_done=1 -> RUN next cycle. If cfg_valid and cfg_done are both high, the entry is written, then the FSM enters RUN. Entering RUN zeroes set pointers and beat counters.
- FSM RUN: cfg_ready=0 and cfg_valid is ignored. cfg_done is ignored.
- cfg_clear (any state): next cycle masks=0, pe_sel=0, counters=0, state=CFG. cfg_clear has priority over cfg_valid and cfg_done. rstn has priority over everything.
- Run datapath, combinational, per router r: M=mask[r][rt_set[r]].
  - rt_ready[r] = RUN & (M==0 | &(pe_ready|~M)).
  - pe_valid[p] = RUN & rt_valid[r] & rt_ready[r] & M[p], for the r,set that own p.
  - Transfer = rt_valid[r]&rt_ready[r]. If M==0, the beat is consumed, dropped and counted, so no deadlock.
  - No partial multicast: either all PEs in M see pe_valid, or none do.
- Per-router beat counter, 0..BURST_LEN-1: increments on transfer. At BURST_LEN-1 with a transfer it wraps to 0 and rt_set[r] increments, wrapping NUM_SETS-1 -> 0. The new set applies from the next cycle.
- Routers are independent, and simultaneous transfers on several routers are legal.

Optional Feature:
- Macro IACT_MCAST_STATS_EN.
- Defined: stall_cnt[r] increments each RUN cycle with rt_valid[r]&~rt_ready[r], saturates at 16'hFFFF, and is cleared by reset or cfg_clear.
- Undefined: stall_cnt is driven constant 0 and no counter flops exist.

Test Plan:
- Reset -> cfg_ready=1, run_active=0, rt_ready=0, pe_valid=0, all pe_sel=0, rt_set=0.
- Config PE0,PE1,PE2 -> router1 set0; cfg_done; rt_valid[1]=1, all pe_ready=1 -> rt_ready[1]=1, pe_valid=12'h007. Clear pe_ready[2] -> rt_ready[1]=0, pe_valid=0.
- BURST_LEN=4, continuous transfers on router1 -> rt_set[1] goes 0->1 on the cycle after the 4th beat. After 16 beats it wraps to 0. An empty-mask set still consumes its 4 beats.
- Write PE5 to router0 set2, then PE5 to router2 set1 -> mask[0][2][5]=0, mask[2][1][5]=1, pe_sel[5]=2.
- In RUN: cfg_valid=1 -> not accepted. Then cfg_clear -> next cycle run_active=0, masks=0, cfg_ready=1. Assert rstn=0 mid-burst -> beat counter and rt_set return to 0.
- IACT_MCAST_STATS_EN: rt_valid[0]=1 for 5 cycles with a needed PE not ready -> stall_cnt[0]=5. Without the macro -> stall_cnt=0.
